// File: rtl/sccb_target_responder_pkg.sv
// Shared constants and FSM state encoding for the SCCB target responder.
package sccb_target_responder_pkg;

    localparam int         SCCB_BYTE_W = 8;
    localparam logic [7:0] OV7670_ID   = 8'h42;
    // Position of the direction bit inside the ID byte (0 = write, 1 = read)
    localparam int         SCCB_RD_BIT = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_ID_ACK,
        S_SUB,
        S_SUB_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RD_NA,
        S_IGNORE
    } sccb_state_e;

endpackage

// File: rtl/sccb_target_responder_if.sv
// SCCB pin bundle plus the register-file strobe/read port of the target responder.
interface sccb_target_responder_if;
    import sccb_target_responder_pkg::*;

    logic                   i_sio_c;
    logic                   i_sio_d;
    logic                   i_sccb_e;
    logic                   o_sio_d_oe;
    logic                   o_sio_d_out;
    logic                   o_wr_en;
    logic [SCCB_BYTE_W-1:0] o_wr_addr;
    logic [SCCB_BYTE_W-1:0] o_wr_data;
    logic [SCCB_BYTE_W-1:0] o_rd_addr;
    logic [SCCB_BYTE_W-1:0] i_rd_data;
    logic                   o_busy;

    modport slave (
        input  i_sio_c, i_sio_d, i_sccb_e, i_rd_data,
        output o_sio_d_oe, o_sio_d_out, o_wr_en, o_wr_addr, o_wr_data, o_rd_addr, o_busy
    );

    modport master (
        output i_sio_c, i_sio_d, i_sccb_e, i_rd_data,
        input  o_sio_d_oe, o_sio_d_out, o_wr_en, o_wr_addr, o_wr_data, o_rd_addr, o_busy
    );

endinterface

// File: rtl/sccb_target_responder_line_monitor.sv
// Synchronizes the asynchronous SCCB pins and turns them into single-cycle bus events.

// N-flop synchronizer with one extra history flop for rise/fall detection.
module edge_detector_n #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer and remember the previous settled level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl_o  = sync_q[STAGES-1];
    assign rise_o = lvl_o & ~prev_q;
    assign fall_o = ~lvl_o & prev_q;
endmodule

module sccb_line_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sio_c_i,
    input  logic sio_d_i,
    input  logic sccb_e_i,
    output logic siod_o,
    output logic sioc_rise_o,
    output logic sioc_fall_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic abort_o
);
    logic                   sioc_lvl;
    logic                   siod_rise;
    logic                   siod_fall;
    logic [SYNC_STAGES-1:0] e_sync_q;

    edge_detector_n #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sioc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sio_c_i),
        .lvl_o (sioc_lvl),
        .rise_o(sioc_rise_o),
        .fall_o(sioc_fall_o)
    );

    edge_detector_n #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_siod (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sio_d_i),
        .lvl_o (siod_o),
        .rise_o(siod_rise),
        .fall_o(siod_fall)
    );

    // SCCB_E only matters as a level, so it gets a plain synchronizer (idles deselected)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e_sync_q <= '1;
        end else begin
            e_sync_q <= {e_sync_q[SYNC_STAGES-2:0], sccb_e_i};
        end
    end

    // SIO_D transitions while SIO_C is high are framing events, never data
    assign start_det_o = siod_fall & sioc_lvl & ~e_sync_q[SYNC_STAGES-1];
    assign stop_det_o  = siod_rise & sioc_lvl;
    assign abort_o     = e_sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/sccb_target_responder.sv
// SCCB camera-side target: decodes ID / sub-address / data phases, acknowledges, and
// serves reads from an external register file addressed by the sub-address pointer.
module sccb_target_responder
    import sccb_target_responder_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = OV7670_ID,
    parameter int         SYNC_STAGES = 2,
    parameter bit         AUTO_INC    = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_reset_p,
    sccb_target_responder_if.slave  bus
);
    sccb_state_e            state_q, state_d;
    logic [SCCB_BYTE_W-1:0] sh_q, sh_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   rd_dir_q, rd_dir_d;
    logic [SCCB_BYTE_W-1:0] rd_addr_q, rd_addr_d;
    logic                   wr_en_q, wr_en_d;
    logic [SCCB_BYTE_W-1:0] wr_addr_q, wr_addr_d;
    logic [SCCB_BYTE_W-1:0] wr_data_q, wr_data_d;
    logic                   oe_q, oe_d;
    logic                   out_q, out_d;

    logic                   siod;
    logic                   sioc_rise;
    logic                   sioc_fall;
    logic                   start_det;
    logic                   stop_det;
    logic                   abort;
    logic [SCCB_BYTE_W-1:0] byte_in;
    logic                   last_bit;

    // Bit counter never passes the ninth clock of a byte
    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'd9) ? c : c + 4'd1;
    endfunction

    sccb_line_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
        .clk_i      (i_clk),
        .rst_i      (i_reset_p),
        .sio_c_i    (bus.i_sio_c),
        .sio_d_i    (bus.i_sio_d),
        .sccb_e_i   (bus.i_sccb_e),
        .siod_o     (siod),
        .sioc_rise_o(sioc_rise),
        .sioc_fall_o(sioc_fall),
        .start_det_o(start_det),
        .stop_det_o (stop_det),
        .abort_o    (abort)
    );

    assign byte_in  = {sh_q[SCCB_BYTE_W-2:0], siod};
    assign last_bit = (cnt_q == 4'd7);

    // State, shift register, pointer and SIO_D driver registers
    always_ff @(posedge i_clk or posedge i_reset_p) begin
        if (i_reset_p) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            rd_dir_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            oe_q      <= 1'b0;
            out_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            rd_dir_q  <= rd_dir_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            oe_q      <= oe_d;
            out_q     <= out_d;
        end
    end

    // Protocol sequencing: framing events first, then per-state SIO_C edge handling
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        rd_dir_d  = rd_dir_q;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        oe_d      = oe_q;
        out_d     = out_q;

        if (abort || stop_det) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            out_d   = 1'b1;
        end else if (start_det) begin
            // Also covers repeated START: any partial byte is simply dropped
            state_d = S_ID;
            cnt_d   = '0;
            oe_d    = 1'b0;
            out_d   = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE, S_IGNORE: ;
                S_ID, S_SUB, S_WDATA: begin
                    if (sioc_rise) begin
                        sh_d  = byte_in;
                        cnt_d = sat_inc(cnt_q);
                        if (last_bit) begin
                            if (state_q == S_ID) begin
                                if (byte_in[7:1] != DEV_ID[7:1]) begin
                                    state_d = S_IGNORE;
                                end else begin
                                    rd_dir_d = byte_in[SCCB_RD_BIT];
                                    state_d  = S_ID_ACK;
                                end
                            end else if (state_q == S_SUB) begin
                                rd_addr_d = byte_in;
                                state_d   = S_SUB_ACK;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = rd_addr_q;
                                wr_data_d = byte_in;
                                if (AUTO_INC) begin
                                    rd_addr_d = rd_addr_q + 8'd1;
                                end
                                state_d = S_WDATA_ACK;
                            end
                        end
                    end
                end
                S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    if (sioc_rise) begin
                        cnt_d = sat_inc(cnt_q);
                    end else if (sioc_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d  = 1'b1;
                            out_d = 1'b0;
                        end else if (cnt_q == 4'd9) begin
                            cnt_d = '0;
                            oe_d  = 1'b0;
                            out_d = 1'b1;
                            if (state_q == S_ID_ACK && rd_dir_q) begin
                                // Hand straight from the ACK low to the first read bit
                                sh_d    = bus.i_rd_data;
                                oe_d    = 1'b1;
                                out_d   = bus.i_rd_data[7];
                                state_d = S_RDATA;
                            end else if (state_q == S_ID_ACK) begin
                                state_d = S_SUB;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (sioc_rise) begin
                        cnt_d = sat_inc(cnt_q);
                    end else if (sioc_fall && cnt_q == 4'd8) begin
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                        state_d = S_RD_NA;
                    end else if (sioc_fall && cnt_q != 4'd0) begin
                        sh_d  = {sh_q[SCCB_BYTE_W-2:0], sh_q[SCCB_BYTE_W-1]};
                        out_d = sh_q[SCCB_BYTE_W-2];
                    end
                end
                S_RD_NA: begin
                    if (sioc_rise) begin
                        cnt_d = sat_inc(cnt_q);
                        if (siod) begin
                            state_d = S_IGNORE;
                        end else if (AUTO_INC) begin
                            // Advance early so the register file has settled by the fall
                            rd_addr_d = rd_addr_q + 8'd1;
                        end
                    end else if (sioc_fall && cnt_q == 4'd9) begin
                        sh_d    = bus.i_rd_data;
                        oe_d    = 1'b1;
                        out_d   = bus.i_rd_data[7];
                        cnt_d   = '0;
                        state_d = S_RDATA;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.o_sio_d_oe  = oe_q;
    assign bus.o_sio_d_out = out_q;
    assign bus.o_wr_en     = wr_en_q;
    assign bus.o_wr_addr   = wr_addr_q;
    assign bus.o_wr_data   = wr_data_q;
    assign bus.o_rd_addr   = rd_addr_q;
    assign bus.o_busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_sccb_target_responder.sv
// Directed bench: drives an SCCB master against two targets (auto-increment and fixed
// pointer) on one shared SIO_D line and scoreboards register-file writes.
module tb_sccb_target_responder;
    import sccb_target_responder_pkg::*;

    localparam int Q = 10;  // quarter SIO_C period in system clocks

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        m_e   = 1'b1;
    logic        sda_line;
    logic [7:0]  regs [256];
    int          tests = 0;
    int          fails = 0;
    int          oe_cnt = 0;
    logic [15:0] exp_q[$], obs_q[$], exp2_q[$], obs2_q[$];

    sccb_target_responder_if bus ();
    sccb_target_responder_if bus2 ();

    sccb_target_responder #(.DEV_ID(8'h42), .SYNC_STAGES(2), .AUTO_INC(1'b1)) dut (
        .i_clk(clk), .i_reset_p(rst), .bus(bus)
    );
    sccb_target_responder #(.DEV_ID(8'h44), .SYNC_STAGES(3), .AUTO_INC(1'b0)) dut_ni (
        .i_clk(clk), .i_reset_p(rst), .bus(bus2)
    );

    always #5 clk = ~clk;

    assign sda_line = m_sda & (bus.o_sio_d_oe ? bus.o_sio_d_out : 1'b1)
                            & (bus2.o_sio_d_oe ? bus2.o_sio_d_out : 1'b1);
    assign bus.i_sio_c   = m_scl;
    assign bus.i_sio_d   = sda_line;
    assign bus.i_sccb_e  = m_e;
    assign bus.i_rd_data = regs[bus.o_rd_addr];
    assign bus2.i_sio_c   = m_scl;
    assign bus2.i_sio_d   = sda_line;
    assign bus2.i_sccb_e  = m_e;
    assign bus2.i_rd_data = regs[bus2.o_rd_addr];

    // Record write strobes and any SIO_D driving, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.o_wr_en)  obs_q.push_back({bus.o_wr_addr, bus.o_wr_data});
        if (bus2.o_wr_en) obs2_q.push_back({bus2.o_wr_addr, bus2.o_wr_data});
        if (bus.o_sio_d_oe || bus2.o_sio_d_oe) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sccb_bit(input logic b, output logic s);
        tick(Q); m_sda = b;
        tick(Q); m_scl = 1'b1;
        tick(Q); s = sda_line;
        tick(Q); m_scl = 1'b0;
    endtask

    task automatic sccb_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0;
    endtask

    task automatic sccb_stop();
        tick(Q); m_sda = 1'b0;
        tick(Q); m_scl = 1'b1;
        tick(Q); m_sda = 1'b1;
        tick(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) sccb_bit(b[i], s);
        sccb_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            sccb_bit(1'b1, s);
            v[i] = s;
        end
        sccb_bit(mack, s);
    endtask

    task automatic drain(input string tag);
        logic [16:0] e, o;
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = '0; o = '0;
            if (exp_q.size() > 0) e = {1'b1, exp_q.pop_front()};
            if (obs_q.size() > 0) o = {1'b1, obs_q.pop_front()};
            chk(tag, 32'(o), 32'(e));
        end
        while (exp2_q.size() > 0 || obs2_q.size() > 0) begin
            e = '0; o = '0;
            if (exp2_q.size() > 0) e = {1'b1, exp2_q.pop_front()};
            if (obs2_q.size() > 0) o = {1'b1, obs2_q.pop_front()};
            chk({tag, "_ni"}, 32'(o), 32'(e));
        end
    endtask

    initial begin
        logic       a0, a1, a2, s;
        logic [7:0] v;
        int         snap;
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        regs[8'h0A] = 8'h76;
        regs[8'h0B] = 8'h5C;

        tick(3);
        chk("rst_oe",      bus.o_sio_d_oe,  0);
        chk("rst_out",     bus.o_sio_d_out, 1);
        chk("rst_wr_en",   bus.o_wr_en,     0);
        chk("rst_wr_addr", bus.o_wr_addr,   0);
        chk("rst_wr_data", bus.o_wr_data,   0);
        chk("rst_rd_addr", bus.o_rd_addr,   0);
        chk("rst_busy",    bus.o_busy,      0);
        rst = 1'b0;
        m_e = 1'b0;
        tick(5);

        // 3-phase write 42/12/80
        exp_q.push_back(16'h1280);
        sccb_start();
        chk("t1_busy", bus.o_busy, 1);
        write_byte(8'h42, a0); write_byte(8'h12, a1); write_byte(8'h80, a2);
        sccb_stop();
        chk("t1_ack_id", a0, 0); chk("t1_ack_sub", a1, 0); chk("t1_ack_data", a2, 0);
        drain("t1_wr");
        chk("t1_idle", bus.o_busy, 0);
        chk("t1_ptr", bus.o_rd_addr, 8'h13);

        // 2-phase write of sub-address, then 2-byte read
        sccb_start(); write_byte(8'h42, a0); write_byte(8'h0A, a1); sccb_stop();
        chk("t2_ptr_set", bus.o_rd_addr, 8'h0A);
        sccb_start(); write_byte(8'h43, a2);
        chk("t2_ack_rd", a2, 0);
        read_byte(1'b0, v); chk("t2_rd0", v, 8'h76);
        read_byte(1'b1, v); chk("t2_rd1", v, 8'h5C);
        sccb_stop();
        chk("t2_no_wr", obs_q.size(), 0);
        chk("t2_ptr_inc", bus.o_rd_addr, 8'h0B);
        chk("t2_idle", bus.o_busy, 0);

        // Foreign ID: nobody drives SIO_D
        snap = oe_cnt;
        sccb_start(); write_byte(8'h60, a0); write_byte(8'h12, a1); write_byte(8'h34, a2); sccb_stop();
        chk("t3_nack", {a0, a1, a2}, 3'b111);
        chk("t3_oe_quiet", oe_cnt, snap);
        chk("t3_no_wr", obs_q.size() + obs2_q.size(), 0);
        chk("t3_idle", bus.o_busy, 0);

        // Pointer wrap with and without auto-increment
        exp_q.push_back(16'hFF11); exp_q.push_back(16'h0022);
        sccb_start(); write_byte(8'h42, a0); write_byte(8'hFF, a1); write_byte(8'h11, a2);
        write_byte(8'h22, s); sccb_stop();
        chk("t4_acks", {a0, a1, a2, s}, 4'b0000);
        chk("t4_ptr", bus.o_rd_addr, 8'h01);
        exp2_q.push_back(16'hFF11); exp2_q.push_back(16'hFF22);
        sccb_start(); write_byte(8'h44, a0); write_byte(8'hFF, a1); write_byte(8'h11, a2);
        write_byte(8'h22, s); sccb_stop();
        chk("t4_ni_acks", {a0, a1, a2, s}, 4'b0000);
        chk("t4_ni_ptr", bus2.o_rd_addr, 8'hFF);
        drain("t4_wr");

        // STOP after 5 data bits
        sccb_start(); write_byte(8'h42, a0); write_byte(8'h12, a1);
        for (int i = 0; i < 5; i++) sccb_bit(i[0], s);
        sccb_stop();
        chk("t5_no_wr", obs_q.size(), 0);
        chk("t5_idle", bus.o_busy, 0);
        chk("t5_ptr", bus.o_rd_addr, 8'h12);

        // Repeated START drops the partial byte and restarts at the ID phase
        exp_q.push_back(16'h2199);
        sccb_start(); write_byte(8'h42, a0); write_byte(8'h20, a1);
        sccb_start(); write_byte(8'h42, a2); write_byte(8'h21, s); write_byte(8'h99, s);
        sccb_stop();
        drain("t7_wr");
        chk("t7_ptr", bus.o_rd_addr, 8'h22);

        // SCCB_E deassertion aborts mid-transfer
        sccb_start(); write_byte(8'h42, a0);
        m_e = 1'b1; tick(Q);
        chk("t8_abort_idle", bus.o_busy, 0);
        chk("t8_abort_oe", bus.o_sio_d_oe, 0);
        m_scl = 1'b1; m_sda = 1'b1; tick(Q);
        m_e = 1'b0; tick(Q);

        // Asynchronous reset during read bit 3
        sccb_start(); write_byte(8'h43, a0);
        sccb_bit(1'b1, s); sccb_bit(1'b1, s);
        tick(Q); tick(Q); m_scl = 1'b1; tick(Q);
        chk("t6_oe_before", bus.o_sio_d_oe, 1);
        rst = 1'b1;
        #1;
        chk("t6_oe_released", bus.o_sio_d_oe, 0);
        chk("t6_busy", bus.o_busy, 0);
        chk("t6_ptr", bus.o_rd_addr, 0);
        tick(2);
        rst = 1'b0;
        m_scl = 1'b0; tick(Q);
        sccb_stop();
        exp_q.push_back(16'h0533);
        sccb_start(); write_byte(8'h42, a0); write_byte(8'h05, a1); write_byte(8'h33, a2); sccb_stop();
        chk("t6_acks", {a0, a1, a2}, 3'b000);
        drain("t6_wr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
